fb_write_scheduler: RTL

FB_WRITE_SCHEDULER -- requirements
Module: fb_write_scheduler

---
 rtl/rt_pkg.sv | 27 ++
 rtl/fb_sweep_counter.sv | 40 ++++
 rtl/fb_write_scheduler.sv | 139 +++++++++++++
 3 files changed

// File: rtl/rt_pkg.sv
// Packet definitions shared by the SPI front end and the frame-buffer controllers.
package rt_pkg;

    typedef enum logic [1:0] {
        PKT_NOP   = 2'b00,
        PKT_PIXEL = 2'b01,
        PKT_CLEAR = 2'b10,
        PKT_SWAP  = 2'b11
    } pkt_type_e;

    localparam int PKT_V_LSB = 24;
    localparam int PKT_H_LSB = 16;

    function automatic logic [7:0] pkt_v(input logic [31:0] d);
        return d[PKT_V_LSB +: 8];
    endfunction

    function automatic logic [7:0] pkt_h(input logic [31:0] d);
        return d[PKT_H_LSB +: 8];
    endfunction

    // 12-bit color is scattered across three nibbles of the packet word.
    function automatic logic [11:0] pkt_color(input logic [31:0] d);
        return {d[3:0], d[15:12], d[11:8]};
    endfunction

endpackage

// File: rtl/fb_sweep_counter.sv
// Raster position counter for the CLEAR sweep: h inner, v outer, stops at the last pixel.
module fb_sweep_counter #(
    parameter int H_SIZE = 160,
    parameter int V_SIZE = 120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic       i_en,
    output logic [7:0] o_h_nxt,
    output logic [7:0] o_v_nxt,
    output logic       o_last
);

    localparam logic [7:0] H_MAX = 8'(H_SIZE - 1);
    localparam logic [7:0] V_MAX = 8'(V_SIZE - 1);

    logic [7:0] r_h;
    logic [7:0] r_v;
    logic       w_h_end;

    assign w_h_end = (r_h == H_MAX);
    assign o_last  = w_h_end && (r_v == V_MAX);
    assign o_h_nxt = w_h_end ? 8'd0 : r_h + 8'd1;
    assign o_v_nxt = w_h_end ? r_v + 8'd1 : r_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h <= 8'd0;
            r_v <= 8'd0;
        end else if (i_clr) begin
            r_h <= 8'd0;
            r_v <= 8'd0;
        end else if (i_en && !o_last) begin
            r_h <= o_h_nxt;
            r_v <= o_v_nxt;
        end
    end

endmodule

// File: rtl/fb_write_scheduler.sv
// Drains the packet FIFO into the back frame buffer: pixel writes, full clears and
// vsync-aligned buffer swaps, one packet in flight at a time.
module fb_write_scheduler
    import rt_pkg::*;
#(
    parameter int H_SIZE = 160,
    parameter int V_SIZE = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fifo_empty,
    input  logic [31:0] fifo_dout,
    input  logic [1:0]  fifo_type,
    input  logic        vsync_start,
    output logic        fifo_re,
    output logic        fb_we,
    output logic [15:0] fb_addr,
    output logic [11:0] fb_data,
    output logic        disp_sel,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  drop_cnt
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_CLEAR   = 3'd3;
    localparam logic [2:0] S_WAIT_VS = 3'd4;

    logic [2:0]  r_state;
    pkt_type_e   r_type;
    logic [11:0] r_color;
    logic        r_we;
    logic [15:0] r_addr;
    logic [11:0] r_data;
    logic        r_disp;
    logic [7:0]  r_drop;

    logic [7:0]  w_h;
    logic [7:0]  w_v;
    logic [11:0] w_color;
    logic        w_in_range;
    logic [7:0]  w_sw_h_nxt;
    logic [7:0]  w_sw_v_nxt;
    logic        w_sw_last;
    logic        w_unused;

    assign w_h        = pkt_h(fifo_dout);
    assign w_v        = pkt_v(fifo_dout);
    assign w_color    = pkt_color(fifo_dout);
    assign w_in_range = (int'(w_h) < H_SIZE) && (int'(w_v) < V_SIZE);
    assign w_unused   = ^fifo_dout[7:4];

    fb_sweep_counter #(.H_SIZE(H_SIZE), .V_SIZE(V_SIZE)) u_sweep (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (r_state == S_DECODE),
        .i_en    (r_state == S_CLEAR),
        .o_h_nxt (w_sw_h_nxt),
        .o_v_nxt (w_sw_v_nxt),
        .o_last  (w_sw_last)
    );

    // Read strobe is combinational so the FIFO sees it in the same IDLE cycle the
    // decision is made; gating with rst_n keeps it quiet while reset is held.
    assign fifo_re    = rst_n && (r_state == S_IDLE) && !fifo_empty;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = (r_state == S_WAIT_VS) && vsync_start;
    assign fb_we      = r_we;
    assign fb_addr    = r_addr;
    assign fb_data    = r_data;
    assign disp_sel   = r_disp;
    assign drop_cnt   = r_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_type  <= PKT_NOP;
            r_color <= 12'd0;
            r_we    <= 1'b0;
            r_addr  <= 16'd0;
            r_data  <= 12'd0;
            r_disp  <= 1'b0;
            r_drop  <= 8'd0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!fifo_empty) r_state <= S_FETCH;
                end
                // FIFO data is valid here; a pixel write is registered now so that
                // fb_we is high during the DECODE cycle.
                S_FETCH: begin
                    r_type  <= pkt_type_e'(fifo_type);
                    r_color <= w_color;
                    r_state <= S_DECODE;
                    if (pkt_type_e'(fifo_type) == PKT_PIXEL) begin
                        if (w_in_range) begin
                            r_we   <= 1'b1;
                            r_addr <= {w_h, w_v};
                            r_data <= w_color;
                        end else if (r_drop != 8'hFF) begin
                            r_drop <= r_drop + 8'd1;
                        end
                    end
                end
                S_DECODE: begin
                    case (r_type)
                        PKT_CLEAR: begin
                            r_state <= S_CLEAR;
                            r_we    <= 1'b1;
                            r_addr  <= 16'd0;
                            r_data  <= r_color;
                        end
                        PKT_SWAP: r_state <= S_WAIT_VS;
                        default:  r_state <= S_IDLE;
                    endcase
                end
                S_CLEAR: begin
                    if (w_sw_last) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_we   <= 1'b1;
                        r_addr <= {w_sw_h_nxt, w_sw_v_nxt};
                    end
                end
                S_WAIT_VS: begin
                    if (vsync_start) begin
                        r_disp  <= ~r_disp;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
